seg_scan_mux: RTL and testbench

Parametrised multiplexed scanner for common-select seven-segment banks. It time-multiplexes `DIGITS` segment codes, chosen from one of `PAGES` display pages, onto one shared segment bus, and drives a one-hot digit select. It adds a programmable scan rate, anti-ghosting dead time, frame-aligned page switching and per-digit blinking. It sits between the counter and score logic and the board display pins.

---
 rtl/seg_scan_pkg.sv | 34 +++
 rtl/seg_scan_mux_if.sv | 33 +++
 rtl/scan_prescaler.sv | 34 +++
 rtl/seg_scan_mux.sv | 142 ++++++++++++++
 tb/tb_seg_scan_mux.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/seg_scan_pkg.sv
// seg_scan_pkg: shared definitions for the multiplexed seven-segment scanner.
//   BLANK_CODE_DEFAULT : all-segments-off code (segments are active low)
//   seg_code_e         : active-low codes for digits 0-9 and blank (dp off)
//   onehot()           : index to one-hot select vector (up to 32 digits)
`timescale 1ns/1ps
package seg_scan_pkg;

  localparam logic [7:0] BLANK_CODE_DEFAULT = 8'hFF;

  // Bit order {dp,g,f,e,d,c,b,a}, low = lit.
  typedef enum logic [7:0] {
    SEG_0     = 8'hC0,
    SEG_1     = 8'hF9,
    SEG_2     = 8'hA4,
    SEG_3     = 8'hB0,
    SEG_4     = 8'h99,
    SEG_5     = 8'h92,
    SEG_6     = 8'h82,
    SEG_7     = 8'hF8,
    SEG_8     = 8'h80,
    SEG_9     = 8'h90,
    SEG_BLANK = 8'hFF
  } seg_code_e;

  // Out-of-range indices give an all-zero select rather than wrapping.
  function automatic logic [31:0] onehot(input logic [31:0] n);
    if (n < 32'd32) begin
      onehot = 32'd1 << n[4:0];
    end else begin
      onehot = 32'd0;
    end
  endfunction

endpackage

// File: rtl/seg_scan_mux_if.sv
// seg_scan_mux_if: display-data and pin bundle of the segment scanner.
//   page_sel    : requested display page
//   page_data   : page p digit i code at [(p*DIGITS+i)*SEG_W +: SEG_W]
//   blink_mask  : per-digit blink enable
//   out_data    : segment bus towards the pins
//   c_pin       : one-hot digit select, active high
//   frame_start : one-cycle pulse at the start of each digit-0 slot
// master = data source (score/counter logic), slave = scanner.
`timescale 1ns/1ps
interface seg_scan_mux_if #(
  parameter int DIGITS = 6,
  parameter int SEG_W  = 8,
  parameter int PAGES  = 2
);
  localparam int PW = (PAGES > 1) ? $clog2(PAGES) : 1;

  logic [PW-1:0]                 page_sel;
  logic [PAGES*DIGITS*SEG_W-1:0] page_data;
  logic [DIGITS-1:0]             blink_mask;
  logic [SEG_W-1:0]              out_data;
  logic [DIGITS-1:0]             c_pin;
  logic                          frame_start;

  modport master (
    output page_sel, page_data, blink_mask,
    input  out_data, c_pin, frame_start
  );

  modport slave (
    input  page_sel, page_data, blink_mask,
    output out_data, c_pin, frame_start
  );
endinterface

// File: rtl/scan_prescaler.sv
// scan_prescaler: free-running 0..DIV-1 counter with a wrap indication.
//   clock : rising-edge clock
//   rst_n : synchronous active-low reset (count returns to 0)
//   cnt   : current count
//   wrap  : high during the last count (DIV-1); the counter returns to 0 on
//           the following edge
`timescale 1ns/1ps
module scan_prescaler #(
  parameter  int DIV = 4,
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1
) (
  input  logic          clock,
  input  logic          rst_n,
  output logic [CW-1:0] cnt,
  output logic          wrap
);

  logic [CW-1:0] cnt_r;

  assign wrap = (cnt_r == CW'(DIV - 1));
  assign cnt  = cnt_r;

  // Count register with wrap back to zero.
  always_ff @(posedge clock) begin
    if (!rst_n) begin
      cnt_r <= {CW{1'b0}};
    end else if (wrap) begin
      cnt_r <= {CW{1'b0}};
    end else begin
      cnt_r <= cnt_r + CW'(1'b1);
    end
  end

endmodule

// File: rtl/seg_scan_mux.sv
// seg_scan_mux: time-multiplexes DIGITS segment codes from one of PAGES pages
// onto a shared segment bus with one-hot digit select, dead time, page
// switching at frame boundaries and per-digit blinking.
//   clock : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : seg_scan_mux_if slave (page_sel, page_data, blink_mask in;
//           out_data, c_pin, frame_start out, all registered)
// The interface instance must carry the same DIGITS/SEG_W/PAGES values.
`timescale 1ns/1ps
module seg_scan_mux
  import seg_scan_pkg::*;
#(
  parameter int               DIGITS       = 6,
  parameter int               SEG_W        = 8,
  parameter int               PAGES        = 2,
  parameter int               SCAN_DIV     = 50000,
  parameter int               DEAD         = 1,
  parameter int               BLINK_FRAMES = 64,
  parameter logic [SEG_W-1:0] BLANK_CODE   = SEG_W'(BLANK_CODE_DEFAULT)
) (
  input  logic           clock,
  input  logic           rst_n,
  seg_scan_mux_if.slave  bus
);

  localparam int PW = (PAGES > 1) ? $clog2(PAGES) : 1;
  localparam int IW = $clog2(DIGITS);
  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [CW-1:0]     cnt_s;
  logic              slot_wrap_s;
  logic              last_digit_s;
  logic              page_ok_s;
  logic              dead_s;
  logic [SEG_W-1:0]  code_s;
  logic [SEG_W-1:0]  out_nx_s;
  logic [DIGITS-1:0] c_pin_nx_s;
  logic              fs_nx_s;

  logic [IW-1:0]     idx_r;
  logic [PW-1:0]     pg_r;
  logic [FW-1:0]     fc_r;
  logic              blink_ph_r;
  logic [SEG_W-1:0]  out_r;
  logic [DIGITS-1:0] c_pin_r;
  logic              fs_r;

  scan_prescaler #(.DIV(SCAN_DIV)) u_slot (
    .clock (clock),
    .rst_n (rst_n),
    .cnt   (cnt_s),
    .wrap  (slot_wrap_s)
  );

  assign last_digit_s = (idx_r == IW'(DIGITS - 1));
  // Out-of-range page requests are ignored, keeping the current page.
  assign page_ok_s    = (32'(bus.page_sel) < 32'(PAGES));

  generate
    if (DEAD == 0) begin : g_no_dead
      assign dead_s = 1'b0;
    end else begin : g_dead
      assign dead_s = (cnt_s < CW'(DEAD));
    end
  endgenerate

  // Digit index, frame-aligned page latch and blink frame counter.
  always_ff @(posedge clock) begin
    if (!rst_n) begin
      idx_r      <= {IW{1'b0}};
      pg_r       <= {PW{1'b0}};
      fc_r       <= {FW{1'b0}};
      blink_ph_r <= 1'b0;
    end else if (slot_wrap_s) begin
      if (last_digit_s) begin
        idx_r <= {IW{1'b0}};
        if (page_ok_s) begin
          pg_r <= bus.page_sel;
        end
        if (fc_r == FW'(BLINK_FRAMES - 1)) begin
          fc_r       <= {FW{1'b0}};
          blink_ph_r <= ~blink_ph_r;
        end else begin
          fc_r <= fc_r + FW'(1'b1);
        end
      end else begin
        idx_r <= idx_r + IW'(1'b1);
      end
    end
  end

  // Live selection of the code for the active page and digit.
  always_comb begin
    code_s = BLANK_CODE;
    for (int p = 0; p < PAGES; p++) begin
      for (int i = 0; i < DIGITS; i++) begin
        if ((pg_r == PW'(p)) && (idx_r == IW'(i))) begin
          code_s = bus.page_data[(p*DIGITS+i)*SEG_W +: SEG_W];
        end else begin
          code_s = code_s;
        end
      end
    end
  end

  // Next pin values: dead time, then the selected digit or blink blanking.
  always_comb begin
    out_nx_s   = BLANK_CODE;
    c_pin_nx_s = {DIGITS{1'b0}};
    fs_nx_s    = (idx_r == {IW{1'b0}}) && (cnt_s == {CW{1'b0}});
    if (dead_s) begin
      out_nx_s   = BLANK_CODE;
      c_pin_nx_s = {DIGITS{1'b0}};
    end else begin
      c_pin_nx_s = DIGITS'(onehot(32'(idx_r)));
      if (bus.blink_mask[idx_r] && blink_ph_r) begin
        out_nx_s = BLANK_CODE;
      end else begin
        out_nx_s = code_s;
      end
    end
  end

  // Output pin registers.
  always_ff @(posedge clock) begin
    if (!rst_n) begin
      out_r   <= BLANK_CODE;
      c_pin_r <= {DIGITS{1'b0}};
      fs_r    <= 1'b0;
    end else begin
      out_r   <= out_nx_s;
      c_pin_r <= c_pin_nx_s;
      fs_r    <= fs_nx_s;
    end
  end

  assign bus.out_data    = out_r;
  assign bus.c_pin       = c_pin_r;
  assign bus.frame_start = fs_r;

endmodule

// File: tb/tb_seg_scan_mux.sv
// tb_seg_scan_mux: directed bench for seg_scan_mux with DIGITS=6, SCAN_DIV=4,
// DEAD=1, BLINK_FRAMES=2; dut1 has PAGES=2, dut2 has PAGES=3.
// Output k after reset release is the pin state of slot k/4, position k%4.
`timescale 1ns/1ps
module tb_seg_scan_mux;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic rst1_n;
  logic rst2_n;

  seg_scan_mux_if #(.DIGITS(6), .SEG_W(8), .PAGES(2)) bus1 ();
  seg_scan_mux_if #(.DIGITS(6), .SEG_W(8), .PAGES(3)) bus2 ();

  seg_scan_mux #(
    .DIGITS(6), .SEG_W(8), .PAGES(2), .SCAN_DIV(4), .DEAD(1),
    .BLINK_FRAMES(2), .BLANK_CODE(8'hFF)
  ) dut1 (
    .clock (clock),
    .rst_n (rst1_n),
    .bus   (bus1)
  );

  seg_scan_mux #(
    .DIGITS(6), .SEG_W(8), .PAGES(3), .SCAN_DIV(4), .DEAD(1),
    .BLINK_FRAMES(2), .BLANK_CODE(8'hFF)
  ) dut2 (
    .clock (clock),
    .rst_n (rst2_n),
    .bus   (bus2)
  );

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic       page;
    logic [5:0] exp_c;
    logic [7:0] exp_d;
    logic       exp_fs;
  } vec_t;

  vec_t tbl [72];

  task automatic check(input string name, input int k,
                       input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0d: actual %0h required %0h", name, k, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    int slot;
    int pos;
    int frm;
    logic [7:0] want;

    // Three frames: page 0, then page_sel=1 raised in the digit-2 slot of
    // frame 1, so frame 1 still shows page 0 and frame 2 shows page 1.
    for (int k = 0; k < 72; k++) begin
      slot = (k / 4) % 6;
      pos  = k % 4;
      tbl[k].page   = (k >= 33);
      tbl[k].exp_fs = ((k % 24) == 0);
      tbl[k].exp_c  = (pos == 0) ? 6'b000000 : 6'(32'd1 << slot);
      tbl[k].exp_d  = (pos == 0) ? 8'hFF
                                 : (((k >= 48) ? 8'h10 : 8'h00) + 8'(slot));
    end

    rst1_n = 1'b0;
    rst2_n = 1'b0;
    bus1.page_sel   = 1'b0;
    bus1.blink_mask = 6'b000000;
    bus2.page_sel   = 2'd1;
    bus2.blink_mask = 6'b000000;
    for (int p = 0; p < 2; p++)
      for (int i = 0; i < 6; i++)
        bus1.page_data[(p*6+i)*8 +: 8] = 8'(p * 16 + i);
    for (int p = 0; p < 3; p++)
      for (int i = 0; i < 6; i++)
        bus2.page_data[(p*6+i)*8 +: 8] = 8'(p * 16 + i);

    repeat (3) tick();
    check("reset_c_pin", -1, 32'(bus1.c_pin), 32'h0);
    check("reset_out_data", -1, 32'(bus1.out_data), 32'hFF);
    check("reset_frame_start", -1, 32'(bus1.frame_start), 32'h0);

    // Reset scan and page switch, one table record per cycle.
    rst1_n = 1'b1;
    for (int k = 0; k < 72; k++) begin
      bus1.page_sel = tbl[k].page;
      tick();
      check("scan_c_pin", k, 32'(bus1.c_pin), 32'(tbl[k].exp_c));
      check("scan_out_data", k, 32'(bus1.out_data), 32'(tbl[k].exp_d));
      check("scan_frame_start", k, 32'(bus1.frame_start), 32'(tbl[k].exp_fs));
    end

    // Reset mid-slot while digit 4 of frame 3 is driven (output 89).
    repeat (18) tick();
    check("pre_reset_c_pin", 89, 32'(bus1.c_pin), 32'h10);
    check("pre_reset_out_data", 89, 32'(bus1.out_data), 32'h14);
    rst1_n = 1'b0;
    tick();
    check("midrst_c_pin", 90, 32'(bus1.c_pin), 32'h0);
    check("midrst_out_data", 90, 32'(bus1.out_data), 32'hFF);
    check("midrst_frame_start", 90, 32'(bus1.frame_start), 32'h0);
    rst1_n = 1'b1;
    tick();
    check("restart_frame_start", 0, 32'(bus1.frame_start), 32'h1);
    check("restart_c_pin", 0, 32'(bus1.c_pin), 32'h0);
    check("restart_out_data", 0, 32'(bus1.out_data), 32'hFF);
    tick();
    // Page returns to 0 on reset even though page_sel is still 1.
    check("restart_digit0_c_pin", 1, 32'(bus1.c_pin), 32'h01);
    check("restart_digit0_data", 1, 32'(bus1.out_data), 32'h00);
    check("restart_frame_start_low", 1, 32'(bus1.frame_start), 32'h0);

    // Blink digit 2: shown in frames 0-1, blank in 2-3, shown in 4-5.
    bus1.page_sel   = 1'b0;
    bus1.blink_mask = 6'b000100;
    for (int k = 2; k < 144; k++) begin
      tick();
      frm = k / 24;
      if ((k % 24) == 9) begin
        want = ((frm == 2) || (frm == 3)) ? 8'hFF : 8'h02;
        check("blink_d2_c_pin", k, 32'(bus1.c_pin), 32'h04);
        check("blink_d2_data", k, 32'(bus1.out_data), 32'(want));
      end
      if ((k % 24) == 13) begin
        check("blink_d3_data", k, 32'(bus1.out_data), 32'h03);
      end
    end
    bus1.blink_mask = 6'b000000;

    // Live data: digit-1 code changes after its second driven cycle.
    for (int k = 144; k <= 150; k++) tick();
    check("live_before_c_pin", 150, 32'(bus1.c_pin), 32'h02);
    check("live_before_data", 150, 32'(bus1.out_data), 32'h01);
    bus1.page_data[1*8 +: 8] = 8'h7F;
    tick();
    check("live_after_c_pin", 151, 32'(bus1.c_pin), 32'h02);
    check("live_after_data", 151, 32'(bus1.out_data), 32'h7F);
    bus1.page_data[1*8 +: 8] = 8'h01;

    // Illegal page on the PAGES=3 build: page 1, then 3 (ignored), then 2.
    rst2_n = 1'b1;
    for (int k = 0; k < 96; k++) begin
      if (k < 30)      bus2.page_sel = 2'd1;
      else if (k < 54) bus2.page_sel = 2'd3;
      else             bus2.page_sel = 2'd2;
      tick();
      slot = (k / 4) % 6;
      frm  = k / 24;
      if ((k % 4) == 1) begin
        case (frm)
          0:       want = 8'h00;
          1, 2:    want = 8'h10;
          default: want = 8'h20;
        endcase
        check("page3_out_data", k, 32'(bus2.out_data), 32'(want + 8'(slot)));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
